// File: rtl/jimbo_bus_responder.sv
// rtl/jimbo_bus_responder.sv - jimbo pin-bus target: nibble RAM plus GPIO/timer/scratch I/O window
`timescale 1ns/1ps
module jimbo_bus_responder #(
  parameter int          RAM_AW   = 6,
  parameter logic [11:0] RAM_BASE = 12'h000,
  parameter logic [11:0] IO_BASE  = 12'hFF0,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bus_addr,
  input  logic        bus_rw,
  input  logic [3:0]  bus_wdata,
  output logic [3:0]  bus_rdata,
  output logic        bus_rdata_oe,
  input  logic [3:0]  gpio_in,
  output logic [3:0]  gpio_out
);

  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  logic [3:0]        ram [0:(1<<RAM_AW)-1];
  logic              io_hit;
  logic              ram_hit;
  logic [11:0]       ram_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0]        io_off;
  logic              wr_io;
  logic              rd_io;
  logic              timer_clr;
  logic [3:0]        rd_val;

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [7:0] cnt;
  logic [7:0] pre;
  logic [3:0] snap;
  logic       en;
  logic [3:0] scratch;

  // I/O window wins over RAM when the two overlap
  assign io_hit    = bus_addr[11:4] == IO_BASE[11:4];
  assign ram_off   = bus_addr - RAM_BASE;
  assign ram_hit   = !io_hit && ((ram_off >> RAM_AW) == 12'd0);
  assign ram_idx   = ram_off[RAM_AW-1:0];
  assign io_off    = bus_addr[3:0];
  assign wr_io     = bus_rw && io_hit;
  assign rd_io     = !bus_rw && io_hit;
  assign timer_clr = wr_io && (io_off == 4'h4) && bus_wdata[1];

  always_comb begin
    rd_val = 4'h0;
    if (io_hit) begin
      case (io_off)
        4'h0:    rd_val = gpio_out;
        4'h1:    rd_val = sync2;
        4'h2:    rd_val = cnt[3:0];
        4'h3:    rd_val = snap;
        4'h4:    rd_val = {3'b000, en};
        4'h5:    rd_val = scratch;
        default: rd_val = 4'h0;
      endcase
    end else if (ram_hit) begin
      rd_val = ram[ram_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus_rw && ram_hit) begin
      ram[ram_idx] <= bus_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata    <= 4'h0;
      bus_rdata_oe <= 1'b0;
      gpio_out     <= 4'h0;
      sync1        <= 4'h0;
      sync2        <= 4'h0;
      cnt          <= 8'h00;
      pre          <= 8'h00;
      snap         <= 4'h0;
      en           <= 1'b0;
      scratch      <= 4'h0;
    end else begin
      sync1        <= gpio_in;
      sync2        <= sync1;
      bus_rdata_oe <= ~bus_rw;
      if (!bus_rw) begin
        bus_rdata <= rd_val;
      end
      if (wr_io) begin
        case (io_off)
          4'h0:    gpio_out <= bus_wdata;
          4'h4:    en       <= bus_wdata[0];
          4'h5:    scratch  <= bus_wdata;
          default: ;
        endcase
      end
      // reading the low half freezes the high half so a LO/HI pair is coherent
      if (rd_io && (io_off == 4'h2)) begin
        snap <= cnt[7:4];
      end
      if (timer_clr) begin
        cnt <= 8'h00;
        pre <= 8'h00;
      end else if (en) begin
        if (pre == PS_LAST) begin
          pre <= 8'h00;
          cnt <= cnt + 8'd1;
        end else begin
          pre <= pre + 8'd1;
        end
      end
    end
  end

endmodule
